data_bus_bridge: RTL and testbench
==================================

DATA_BUS_BRIDGE -- requirements
Module: data_bus_bridge

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 18, data address width.
REQ-002 SHALL have parameter WORD_SIZE, default 18, data word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries, power of two, at most 16.
REQ-004 SHALL have port clock  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
REQ-006 SHALL have ports cpu_addr in ADDR_SIZE, cpu_write_enable in 1, cpu_data_in in WORD_SIZE: processor data-port address, write strobe and write data.
REQ-007 SHALL have port cpu_data_out  out  WORD_SIZE  read data returned to the processor.
REQ-008 SHALL have ports ram_addr out ADDR_SIZE, ram_write_enable out 1, ram_data_in out WORD_SIZE, ram_data_out in WORD_SIZE: synchronous RAM with 1-cycle read latency.
REQ-009 SHALL have ports tx_data out WORD_SIZE, tx_valid out 1, tx_ready in 1: FIFO drain stream to a peripheral.

Function
REQ-010 SHALL decode IO space as cpu_addr >= 2^ADDR_SIZE-16 (0x3FFF0..0x3FFFF at default); all other addresses SHALL be RAM space.
REQ-011 SHALL drive ram_addr=cpu_addr and ram_data_in=cpu_data_in combinationally; ram_write_enable=cpu_write_enable only for RAM space, else 0.
REQ-012 SHALL return read data exactly 1 cycle after the address: register an io_select flag and io_read_data each cycle; cpu_data_out = io_select ? io_read_data : ram_data_out.
REQ-013 IO map: +0 TX_DATA, +1 STATUS, +2 TIMER_LO, +3 TIMER_HI, +4..+15 reserved.
REQ-014 Write to TX_DATA SHALL push cpu_data_in into the FIFO if not full; if full, data SHALL be dropped and sticky overflow SHALL be set.
REQ-015 TX_DATA read SHALL return 0.
REQ-016 STATUS read SHALL return bit0 full, bit1 empty, bit2 overflow, bits[7:3] FIFO count (0..FIFO_DEPTH), other bits 0; values sampled in the address cycle.
REQ-017 Any write to STATUS SHALL clear overflow; if it coincides with an overflow event the set SHALL win.
REQ-018 Timer SHALL be a 2*WORD_SIZE-bit free-running counter, +1 every cycle, wrapping to 0 after all-ones.
REQ-019 TIMER_LO read SHALL return counter low word and in the same cycle latch the high word into a shadow register; TIMER_HI read SHALL return the shadow.
REQ-020 Any write to TIMER_LO or TIMER_HI SHALL load counter to 0 on that edge (next cycle reads 0 before increment is visible).
REQ-021 Reserved IO reads SHALL return 0; reserved IO writes SHALL be ignored.
REQ-022 FIFO SHALL drain in order: tx_valid = not empty; tx_data = head entry, registered; pop when tx_valid & tx_ready.
REQ-023 Simultaneous push and pop: when full, pop frees a slot and push SHALL be accepted (count unchanged, no overflow); when empty, no bypass (tx_valid rises the cycle after push).
REQ-024 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH nor go below 0.
REQ-025 tx_data and tx_valid SHALL not change while tx_valid=1 and tx_ready=0.

Reset
REQ-026 On reset: FIFO empty (pointers, count 0), tx_valid=0, overflow=0, timer=0, shadow=0, io_select=0, io_read_data=0.
REQ-027 During reset ram_write_enable SHALL still follow REQ-011 (RAM pass-through is combinational); no FIFO push or timer write takes effect.
REQ-028 Reset asserted mid-drain SHALL discard all FIFO contents; tx_valid=0 the cycle after the reset edge.

Verification
REQ-029 Write 0x00041 to 0x3FFF0 with tx_ready=1 -> tx_valid=1, tx_data=0x00041 next cycle, one beat, then tx_valid=0.
REQ-030 tx_ready=0, push 9 words -> STATUS read returns 0x00045 (full, overflow, count 8); 9th word absent from drain; STATUS write clears bit2.
REQ-031 Full FIFO, tx_ready=1 and push same cycle -> count stays 8, overflow stays 0, order preserved.
REQ-032 Force timer to 0x3FFFF low/0 high, read TIMER_LO then TIMER_HI -> 0x3FFFF then 0x00000; next pair shows carry into high.
REQ-033 RAM read at 0x00010 followed by IO read of STATUS next cycle -> cpu_data_out shows RAM word then STATUS 0x00002, each 1 cycle after its address.
REQ-034 Write 0x12345 to 0x3FFF8 (reserved) and 0x3FFEF (RAM) -> no FIFO/timer change; ram_write_enable=1 only for 0x3FFEF.

Source files
------------

// File: rtl/data_bus_bridge.sv
// data_bus_bridge: splits the CPU data port into RAM and a 16-word IO page
// (TX FIFO, status, 2-word timer) and returns read data one cycle later.
module data_bus_bridge #(
  parameter int ADDR_SIZE  = 18,
  parameter int WORD_SIZE  = 18,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  input  logic                 cpu_write_enable,
  input  logic [WORD_SIZE-1:0] cpu_data_in,
  output logic [WORD_SIZE-1:0] cpu_data_out,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic                 ram_write_enable,
  output logic [WORD_SIZE-1:0] ram_data_in,
  input  logic [WORD_SIZE-1:0] ram_data_out,
  output logic [WORD_SIZE-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = 2 * WORD_SIZE;

  logic                 w_io;
  logic [3:0]           w_off;
  logic                 w_wr;
  logic                 w_wr_tx;
  logic                 w_wr_st;
  logic                 w_wr_tm;
  logic                 w_rd_lo;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_ovf_set;
  logic [WORD_SIZE-1:0] w_status;
  logic [WORD_SIZE-1:0] w_rd_data;

  logic [WORD_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_wp;
  logic [PW-1:0]        r_rp;
  logic [CW-1:0]        r_cnt;
  logic                 r_ovf;
  logic [TW-1:0]        r_tmr;
  logic [WORD_SIZE-1:0] r_shadow;
  logic                 r_io_sel;
  logic [WORD_SIZE-1:0] r_io_data;

  // IO page is the top 16 words of the address space
  assign w_io  = &cpu_addr[ADDR_SIZE-1:4];
  assign w_off = cpu_addr[3:0];

  assign ram_addr         = cpu_addr;
  assign ram_data_in      = cpu_data_in;
  assign ram_write_enable = cpu_write_enable & ~w_io;
  assign cpu_data_out     = r_io_sel ? r_io_data : ram_data_out;

  assign w_wr    = w_io & cpu_write_enable;
  assign w_wr_tx = w_wr & (w_off == 4'd0);
  assign w_wr_st = w_wr & (w_off == 4'd1);
  assign w_wr_tm = w_wr & ((w_off == 4'd2) | (w_off == 4'd3));
  assign w_rd_lo = w_io & ~cpu_write_enable & (w_off == 4'd2);

  assign w_full    = (r_cnt == CW'(FIFO_DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign tx_valid  = ~w_empty;
  assign tx_data   = r_mem[r_rp];
  assign w_pop     = tx_valid & tx_ready;
  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign w_push    = w_wr_tx & (~w_full | w_pop);
  assign w_ovf_set = w_wr_tx & w_full & ~w_pop;

  always_comb begin
    w_status      = '0;
    w_status[0]   = w_full;
    w_status[1]   = w_empty;
    w_status[2]   = r_ovf;
    w_status[7:3] = 5'(r_cnt);
  end

  always_comb begin
    w_rd_data = '0;
    unique case (1'b1)
      w_off == 4'd1: w_rd_data = w_status;
      w_off == 4'd2: w_rd_data = r_tmr[WORD_SIZE-1:0];
      w_off == 4'd3: w_rd_data = r_shadow;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset && w_push) r_mem[r_wp] <= cpu_data_in;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_tmr     <= '0;
      r_shadow  <= '0;
      r_io_sel  <= 1'b0;
      r_io_data <= '0;
    end else begin
      r_io_sel  <= w_io;
      r_io_data <= w_rd_data;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
      r_ovf <= w_ovf_set | (r_ovf & ~w_wr_st);
      r_tmr <= w_wr_tm ? '0 : r_tmr + 1'b1;
      if (w_rd_lo) r_shadow <= r_tmr[TW-1:WORD_SIZE];
    end
  end

endmodule

// File: tb/tb_data_bus_bridge.sv
// tb_data_bus_bridge: random + directed bus traffic against a queue-based
// model of the IO page, plus a small-width instance for the timer carry.
module tb_data_bus_bridge;

  localparam int A = 18;
  localparam int W = 18;
  localparam int D = 8;
  localparam logic [A-1:0] IOB = 18'h3FFF0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [A-1:0] cpu_addr;
  logic         cpu_write_enable;
  logic [W-1:0] cpu_data_in;
  logic [W-1:0] cpu_data_out;
  logic [A-1:0] ram_addr;
  logic         ram_write_enable;
  logic [W-1:0] ram_data_in;
  logic [W-1:0] ram_q;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;

  data_bus_bridge dut (
    .clock(clk), .reset(rst_n),
    .cpu_addr(cpu_addr), .cpu_write_enable(cpu_write_enable),
    .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
    .ram_addr(ram_addr), .ram_write_enable(ram_write_enable),
    .ram_data_in(ram_data_in), .ram_data_out(ram_q),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  logic [7:0] s_addr;
  logic       s_we;
  logic [7:0] s_din;
  logic [7:0] s_dout;
  logic [7:0] s_raddr;
  logic       s_rwe;
  logic [7:0] s_rdin;
  logic [7:0] s_ram_q;
  logic [7:0] s_txd;
  logic       s_txv;
  logic       s_rdy;

  data_bus_bridge #(.ADDR_SIZE(8), .WORD_SIZE(8), .FIFO_DEPTH(4)) dut_s (
    .clock(clk), .reset(rst_n),
    .cpu_addr(s_addr), .cpu_write_enable(s_we),
    .cpu_data_in(s_din), .cpu_data_out(s_dout),
    .ram_addr(s_raddr), .ram_write_enable(s_rwe),
    .ram_data_in(s_rdin), .ram_data_out(s_ram_q),
    .tx_data(s_txd), .tx_valid(s_txv), .tx_ready(s_rdy)
  );

  // Environment RAM: 256 words aliased on the low address byte
  logic [W-1:0] ram [256];
  logic         ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= W'(i * 7 + 3);
      ram_q <= '0;
    end else begin
      ram_q <= ram[ram_addr[7:0]];
      if (ram_write_enable) ram[ram_addr[7:0]] <= ram_data_in;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0]   q[$];
  logic           m_ovf;
  logic [2*W-1:0] m_tmr;
  logic [W-1:0]   m_shadow;
  logic           m_io_sel;
  logic [W-1:0]   m_io_data;
  logic [W-1:0]   m_ram_rd;
  logic [W-1:0]   mmem [256];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [A-1:0] a, input logic we,
                       input logic [W-1:0] d, input logic rdy,
                       input logic rst);
    logic io;
    int off;
    int n;
    logic pop;
    logic ovf_set;
    logic [W-1:0] st;
    logic [W-1:0] rd;
    cpu_addr = a;
    cpu_write_enable = we;
    cpu_data_in = d;
    tx_ready = rdy;
    rst_n = rst;
    io = (a >= IOB);
    off = io ? int'(a - IOB) : -1;
    @(negedge clk);
    n = q.size();
    chk("ram_we", ram_write_enable, we && !io);
    chk("ram_addr", ram_addr, a);
    chk("ram_din", ram_data_in, d);
    chk("tx_valid", tx_valid, n != 0);
    if (n != 0) chk("tx_data", tx_data, q[0]);
    chk("rdata", cpu_data_out, m_io_sel ? m_io_data : m_ram_rd);
    m_ram_rd = mmem[a[7:0]];
    if (we && !io) mmem[a[7:0]] = d;
    if (!rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_tmr = '0;
      m_shadow = '0;
      m_io_sel = 1'b0;
      m_io_data = '0;
    end else begin
      st = '0;
      st[0] = (n == D);
      st[1] = (n == 0);
      st[2] = m_ovf;
      st[7:3] = 5'(n);
      case (off)
        1: rd = st;
        2: rd = m_tmr[W-1:0];
        3: rd = m_shadow;
        default: rd = '0;
      endcase
      m_io_sel = io;
      m_io_data = rd;
      pop = (n != 0) && rdy;
      ovf_set = 1'b0;
      if (pop) void'(q.pop_front());
      if (io && we && off == 0) begin
        if (n < D || pop) q.push_back(d);
        else ovf_set = 1'b1;
      end
      if (ovf_set) m_ovf = 1'b1;
      else if (io && we && off == 1) m_ovf = 1'b0;
      if (io && !we && off == 2) m_shadow = m_tmr[2*W-1:W];
      if (io && we && (off == 2 || off == 3)) m_tmr = '0;
      else m_tmr = m_tmr + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    cpu_addr = '0;
    cpu_write_enable = 1'b0;
    cpu_data_in = '0;
    tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_tmr = '0;
    m_shadow = '0;
    m_io_sel = 1'b0;
    m_io_data = '0;
    m_ram_rd = mmem[0];
  endtask

  initial begin
    logic [A-1:0] a;
    logic we;
    logic rdy;
    logic rs;
    logic [W-1:0] d;
    int o;
    for (int i = 0; i < 256; i++) mmem[i] = W'(i * 7 + 3);
    s_addr = '0;
    s_we = 1'b0;
    s_din = '0;
    s_ram_q = '0;
    s_rdy = 1'b0;
    rst_n = 1'b0;
    cpu_addr = '0;
    cpu_write_enable = 1'b0;
    cpu_data_in = '0;
    tx_ready = 1'b0;
    @(posedge clk);
    #1;
    ram_init = 1'b1;
    reset_all();

    // 8-bit instance: timer low word wraps after 256 cycles
    rst_n = 1'b1;
    s_addr = 8'hF2;
    s_we = 1'b1;
    @(posedge clk);
    #1;
    s_we = 1'b0;
    s_addr = 8'h00;
    repeat (255) @(posedge clk);
    #1;
    s_addr = 8'hF2;
    @(posedge clk);
    #1;
    chk("s_tlo_ff", s_dout, 8'hFF);
    s_addr = 8'hF3;
    @(posedge clk);
    #1;
    chk("s_thi_0", s_dout, 8'h00);
    s_addr = 8'hF2;
    @(posedge clk);
    #1;
    chk("s_tlo_1", s_dout, 8'h01);
    s_addr = 8'hF3;
    @(posedge clk);
    #1;
    chk("s_thi_carry", s_dout, 8'h01);
    s_addr = 8'h00;

    reset_all();
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_rdata", cpu_data_out, 18'h3);

    apply(IOB, 1'b1, 18'h00041, 1'b1, 1'b1);
    chk("one_valid", tx_valid, 1'b1);
    chk("one_data", tx_data, 18'h00041);
    apply(18'h10, 1'b0, '0, 1'b1, 1'b1);
    chk("one_done", tx_valid, 1'b0);

    for (int i = 0; i < 9; i++) apply(IOB, 1'b1, W'(18'h100 + i), 1'b0, 1'b1);
    apply(IOB + 1, 1'b0, '0, 1'b0, 1'b1);
    chk("ovf_status", cpu_data_out, 18'h00045);
    apply(IOB + 1, 1'b1, '0, 1'b0, 1'b1);
    apply(IOB + 1, 1'b0, '0, 1'b0, 1'b1);
    chk("ovf_cleared", cpu_data_out, 18'h00041);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_order", tx_data, W'(18'h100 + i));
      apply(18'h10, 1'b0, '0, 1'b1, 1'b1);
    end
    chk("ovf_drained", tx_valid, 1'b0);

    for (int i = 0; i < 8; i++) apply(IOB, 1'b1, W'(18'h180 + i), 1'b0, 1'b1);
    apply(IOB, 1'b1, 18'h200, 1'b1, 1'b1);
    apply(IOB + 1, 1'b0, '0, 1'b0, 1'b1);
    chk("pushpop_status", cpu_data_out, 18'h00041);
    for (int i = 1; i < 9; i++) begin
      chk("pushpop_order", tx_data, (i == 8) ? 18'h200 : W'(18'h180 + i));
      apply(18'h10, 1'b0, '0, 1'b1, 1'b1);
    end

    apply(18'h10, 1'b0, '0, 1'b0, 1'b1);
    chk("ram_rd", cpu_data_out, 18'h73);
    apply(IOB + 1, 1'b0, '0, 1'b0, 1'b1);
    chk("io_after_ram", cpu_data_out, 18'h00002);

    apply(IOB + 3, 1'b1, 18'h5, 1'b0, 1'b1);
    apply(IOB + 2, 1'b0, '0, 1'b0, 1'b1);
    chk("tmr_zero", cpu_data_out, 18'h0);
    apply(IOB + 3, 1'b0, '0, 1'b0, 1'b1);
    chk("tmr_hi_zero", cpu_data_out, 18'h0);
    repeat (4) apply(18'h10, 1'b0, '0, 1'b0, 1'b1);
    apply(IOB + 2, 1'b0, '0, 1'b0, 1'b1);
    chk("tmr_six", cpu_data_out, 18'h6);

    apply(IOB + 8, 1'b1, 18'h12345, 1'b0, 1'b1);
    apply(18'h3FFEF, 1'b1, 18'h12345, 1'b0, 1'b1);
    chk("rsv_fifo", tx_valid, 1'b0);
    apply(18'h3FFEF, 1'b0, '0, 1'b0, 1'b1);
    chk("ram_top_rd", cpu_data_out, 18'h12345);
    apply(IOB + 8, 1'b0, '0, 1'b0, 1'b1);
    chk("rsv_rd", cpu_data_out, 18'h0);

    for (int i = 0; i < 3; i++) apply(IOB, 1'b1, W'(18'h300 + i), 1'b0, 1'b1);
    apply(18'h10, 1'b0, '0, 1'b1, 1'b0);
    chk("rst_drain", tx_valid, 1'b0);
    apply(IOB + 1, 1'b0, '0, 1'b0, 1'b1);
    chk("rst_status", cpu_data_out, 18'h00002);

    for (int k = 0; k < 3000; k++) begin
      d = W'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        o = $urandom_range(6, 0);
        if (o <= 1) a = IOB;
        else if (o <= 4) a = IOB + A'(o - 1);
        else a = IOB + A'($urandom_range(15, 4));
        if (a == IOB + 2 || a == IOB + 3) we = ($urandom_range(7, 0) == 0);
        else we = $urandom_range(1, 0) == 1;
      end else begin
        if ($urandom_range(1, 0) == 1) a = A'($urandom_range(255, 0));
        else a = 18'h3FF00 + A'($urandom_range(239, 0));
        we = $urandom_range(1, 0) == 1;
      end
      if (((k / 300) % 2) == 1) rdy = ($urandom_range(3, 0) == 0);
      else rdy = ($urandom_range(3, 0) != 0);
      rs = ($urandom_range(499, 0) != 0);
      apply(a, we, d, rdy, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
